// File: rtl/spi_pkg.sv
// Shared constants for the CRC-framed SPI link (slave and master).
// Frame: DATA_W payload bits then CRC-8 (poly 0x1D, init 0xFF, no reflection,
// no final XOR), MSB first.
package spi_pkg;
  localparam logic [7:0] CRC_POLY   = 8'h1D;
  localparam logic [7:0] CRC_INIT   = 8'hFF;
  localparam int         FRAME_BITS = 32;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  // One serial CRC step, MSB first.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator.
// Ports: clk/rst (async high), clr reloads CRC_INIT, en folds bit_in,
//        crc is the running remainder.
module crc8_serial
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc8_next(crc, bit_in);
  end
endmodule

// File: rtl/spi_slave_crc.sv
// SPI responder (mode: master drives on sck rise, samples on sck fall) for
// the 32-bit CRC-framed link. Oversamples sck/csn/mosi on clk.
// Ports: clk, rst (async high); sck, csn, mosi, miso (SPI pins);
//        tx_data (word returned, captured at csn fall);
//        rx_data/rx_crc/crc_ok (last good frame), rx_valid / frame_err
//        (one-clk pulses at frame end), busy (frame in progress).
module spi_slave_crc
  import spi_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int CRC_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              csn,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic [CRC_W-1:0]  rx_crc,
  output logic              rx_valid,
  output logic              crc_ok,
  output logic              frame_err,
  output logic              busy
);
  localparam int            CW      = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] DATA_N  = CW'(DATA_W);
  localparam logic [CW-1:0] FRAME_N = CW'(FRAME_BITS);

  // synchronisers plus one edge-detect flop each for sck and csn
  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic sck_d, csn_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      csn_d     <= csn_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, csn_s, mosi_s;
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic sck_rise, sck_fall, csn_rise, csn_fall;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csn_rise = csn_s & ~csn_d;
  assign csn_fall = ~csn_s & csn_d;

  state_t              state;
  logic [DATA_W-1:0]   tx_shift, rx_shift;
  logic [CRC_W-1:0]    tx_crc, rx_crc_calc, tx_crc_shift, rx_crc_shift;
  logic [CW-1:0]       bit_cnt, tx_cnt;

  // sck edges coinciding with the csn rise are dropped
  logic act_rise, act_fall, crc_clr;
  assign act_rise = (state == ACTIVE) && !csn_rise && sck_rise;
  assign act_fall = (state == ACTIVE) && !csn_rise && sck_fall;
  assign crc_clr  = (state == IDLE) && csn_fall;

  crc8_serial u_tx_crc (
    .clk(clk), .rst(rst), .clr(crc_clr),
    .en(act_rise && (tx_cnt < DATA_N)), .bit_in(tx_shift[DATA_W-1]),
    .crc(tx_crc)
  );

  crc8_serial u_rx_crc (
    .clk(clk), .rst(rst), .clr(crc_clr),
    .en(act_fall && (bit_cnt < DATA_N)), .bit_in(mosi_s),
    .crc(rx_crc_calc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      miso         <= 1'b0;
      busy         <= 1'b0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      crc_ok       <= 1'b0;
      rx_data      <= '0;
      rx_crc       <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      tx_crc_shift <= '0;
      rx_crc_shift <= '0;
      bit_cnt      <= '0;
      tx_cnt       <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          busy <= 1'b0;
          if (csn_fall) begin
            tx_shift <= tx_data;
            bit_cnt  <= '0;
            tx_cnt   <= '0;
            busy     <= 1'b1;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (csn_rise) begin
            state <= DONE;
          end else begin
            if (sck_rise) begin
              if (tx_cnt < DATA_N) begin
                miso     <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              end else if (tx_cnt == DATA_N) begin
                // tx_crc is final once the last payload bit was folded
                miso         <= tx_crc[CRC_W-1];
                tx_crc_shift <= {tx_crc[CRC_W-2:0], 1'b0};
              end else if (tx_cnt < FRAME_N) begin
                miso         <= tx_crc_shift[CRC_W-1];
                tx_crc_shift <= {tx_crc_shift[CRC_W-2:0], 1'b0};
              end else begin
                miso <= 1'b0;
              end
              if (tx_cnt != FRAME_N) tx_cnt <= tx_cnt + CW'(1);
            end
            if (sck_fall) begin
              if (bit_cnt < DATA_N)
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
              else if (bit_cnt < FRAME_N)
                rx_crc_shift <= {rx_crc_shift[CRC_W-2:0], mosi_s};
              if (bit_cnt != FRAME_N) bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          miso  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (bit_cnt == FRAME_N) begin
            rx_data  <= rx_shift;
            rx_crc   <= rx_crc_shift;
            crc_ok   <= (rx_crc_shift == rx_crc_calc);
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_slave_crc.md
Name: spi_slave_crc

Overview:
- SPI responder for the 32-bit CRC framed link driven by the team's SPI master.
- Frame format: 24 data bits, then an 8-bit CRC-8 of those data bits, MSB first.
- Runs on the system clock and oversamples sck, csn and mosi. Deserialises and CRC-checks the incoming frame while returning its own 24-bit word plus CRC on miso.
- Sits between the SPI pins and a local register/RAM client. That client supplies tx_data and consumes rx_data through a valid pulse.

Parameters:
- DATA_W, 24, payload bits per frame.
- CRC_W, 8, CRC bits per frame; frame length = DATA_W + CRC_W = 32.
- SYNC_STAGES, 2, synchroniser flops on sck, csn and mosi (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sck  in  1  SPI clock from master; idle low.
- csn  in  1  chip select from master; active low.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- tx_data  in  DATA_W  word returned in the next frame; captured at frame start.
- rx_data  out  DATA_W  last received payload; held until the next valid frame.
- rx_crc  out  CRC_W  CRC field received in the last frame.
- rx_valid  out  1  one-clk pulse when a complete 32-bit frame has been received.
- crc_ok  out  1  valid with rx_valid; 1 when rx_crc equals the locally computed CRC.
- frame_err  out  1  one-clk pulse when csn deasserts with bit count not equal to 32.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset: every output is 0. Internal state: crc regs = 8'hFF, bit_cnt = 0, FSM = IDLE.
- Input conditioning:
  - sck, csn and mosi each pass through SYNC_STAGES flops.
  - Edge detect uses one extra flop, so an event reaches the logic SYNC_STAGES+1 clk after the pin.
  - Required: master sck half-period ≥ SYNC_STAGES+2 clk. At the defaults that is 4 clk, which matches master CLK_DIV=4.
- SPI mode:
  - Master drives mosi on sck rise and samples miso on sck fall.
  - Slave samples mosi on the synced sck fall and updates miso on the synced sck rise.
- CRC:
  - CRC-8, poly 8'h1D, init 8'hFF, no reflection, no final XOR.
  - Computed serially MSB first: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h1D : 0).
  - Applies only to the first DATA_W bits of a frame.
- FSM states:
  - IDLE:
    - miso = 0, busy = 0.
    - On synced csn fall: latch tx_data into tx_shift, reset both CRC regs to 8'hFF, bit_cnt = 0, go to ACTIVE.
  - ACTIVE:
    - busy = 1.
    - On sck rise, for tx bit k (k = 0..31): k < 24 → miso = tx_shift[23-k] and fold that bit into tx_crc; k ≥ 24 → miso = tx_crc[31-k].
    - The tx bit index advances on every rise.
    - On sck fall: k < 24 → shift mosi into rx_shift and fold it into rx_crc_calc; else shift mosi into rx_crc_shift. bit_cnt++ (saturates at 32).
    - On synced csn rise: go to DONE.
  - DONE (1 clk):
    - bit_cnt == 32: rx_data ← rx_shift, rx_crc ← rx_crc_shift, crc_ok ← (rx_crc_shift == rx_crc_calc), rx_valid = 1.
    - Otherwise: frame_err = 1; rx_data, rx_crc and crc_ok are unchanged.
    - Go to IDLE. miso returns to 0.
- Latency: rx_valid asserts SYNC_STAGES+2 clk after the csn pin rises.
- Boundary conditions:
  - More than 32 sck falls: extra bits are ignored and bit_cnt stays 32. The frame is still valid if the first 32 bits are good. miso drives 0 after bit 31.
  - csn rising in the same clk as an sck edge: csn wins and that edge is discarded.
  - tx_data changing mid-frame has no effect on the frame in flight.
  - rst asserted mid-frame: immediate return to the reset state. No rx_valid and no frame_err for the aborted frame.
  - sck toggling while csn is high is ignored.
  - rx_valid and frame_err are never both high.

Decomposition:
- Package spi_pkg:
  - CRC_POLY = 8'h1D, CRC_INIT = 8'hFF, FRAME_BITS = 32.
  - state_t enum {IDLE, ACTIVE, DONE}.
  - The master is to import the same constants.
- Sub-module crc8_serial (clk, rst, clr, en, bit_in, crc):
  - Instantiated twice, once for the tx CRC and once for the rx CRC.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset, then master sends 24'hABCDEF + 8'h6F → rx_valid one pulse, rx_data = 24'hABCDEF, rx_crc = 8'h6F, crc_ok = 1.
- Same frame with CRC byte 8'h6E → rx_valid pulse, rx_data = 24'hABCDEF, crc_ok = 0.
- tx_data = 24'hABCDEF; sample miso on each sck fall over 32 bits → master captures 32'hABCDEF6F.
- csn raised after 20 sck cycles → frame_err one pulse, no rx_valid, rx_data keeps its previous value; the next full frame decodes correctly.
- rst pulsed after 10 bits, then a full 24'h123456 frame with correct CRC → all outputs 0 during reset, then rx_valid with rx_data = 24'h123456 and crc_ok = 1.
- Back-to-back frames with a 2-sck csn-high gap, and tx_data changed mid-frame → each frame returns the tx_data present at its csn fall; two rx_valid pulses.
